// File: rtl/divisor_secuencial.sv
`default_nettype none
// ============================================================================
// Module  : divisor_secuencial
// Brief   : Sequential signed restoring divider, one quotient bit per clock.
// Revision: 1.0 - initial release
// ============================================================================
module divisor_secuencial #(
   parameter int SIZE = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            Inicio,
   input  logic [SIZE-1:0] dividendo,
   input  logic [SIZE-1:0] divisor,
   output logic [SIZE-1:0] cociente,
   output logic [SIZE-1:0] resto,
   output logic            Fin,
   output logic            Error
);

   localparam int c_CNT_W = $clog2(SIZE + 1);

   typedef enum logic [1:0] {
      REPOSO = 2'd0,
      OPERA  = 2'd1,
      AJUSTE = 2'd2,
      FIN    = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [SIZE-1:0]    r_q;
   logic [SIZE-1:0]    r_m;
   logic [SIZE:0]      r_a;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_sign_dd;
   logic               r_sign_dv;
   logic               r_ovf;
   logic [SIZE-1:0]    r_cociente;
   logic [SIZE-1:0]    r_resto;
   logic               r_error;

   logic               w_idle;
   logic               w_accept;
   logic               w_div_zero;
   logic               w_ovf;
   logic               w_last;
   logic [SIZE-1:0]    w_mag_dd;
   logic [SIZE-1:0]    w_mag_dv;
   logic [SIZE:0]      w_shift_a;
   logic [SIZE+1:0]    w_diff;
   logic               w_neg;

   assign w_idle     = (r_state == REPOSO) || (r_state == FIN);
   assign w_accept   = w_idle && Inicio;
   assign w_div_zero = (divisor == '0);
   assign w_ovf      = (dividendo == {1'b1, {(SIZE-1){1'b0}}}) && (divisor == '1);
   assign w_last     = (r_cnt == c_CNT_W'(SIZE - 1));

   // Magnitudes are unsigned SIZE bits, so the most negative value maps to 2^(SIZE-1).
   assign w_mag_dd = dividendo[SIZE-1] ? -dividendo : dividendo;
   assign w_mag_dv = divisor[SIZE-1]   ? -divisor   : divisor;

   // One extra bit on the trial subtraction keeps its sign unambiguous for any A.
   assign w_shift_a = {r_a[SIZE-1:0], r_q[SIZE-1]};
   assign w_diff    = {1'b0, w_shift_a} - {2'b00, r_m};
   assign w_neg     = w_diff[SIZE+1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= REPOSO;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         REPOSO, FIN: begin
            if (Inicio) begin
               w_state_next = w_div_zero ? FIN : OPERA;
            end
         end
         OPERA: begin
            if (w_last) begin
               w_state_next = AJUSTE;
            end
         end
         AJUSTE:  w_state_next = FIN;
         default: w_state_next = REPOSO;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q        <= '0;
         r_m        <= '0;
         r_a        <= '0;
         r_cnt      <= '0;
         r_sign_dd  <= 1'b0;
         r_sign_dv  <= 1'b0;
         r_ovf      <= 1'b0;
         r_cociente <= '0;
         r_resto    <= '0;
         r_error    <= 1'b0;
      end else begin
         case (r_state)
            REPOSO, FIN: begin
               if (w_accept) begin
                  if (w_div_zero) begin
                     r_cociente <= '1;
                     r_resto    <= dividendo;
                     r_error    <= 1'b1;
                  end else begin
                     r_error   <= 1'b0;
                     r_sign_dd <= dividendo[SIZE-1];
                     r_sign_dv <= divisor[SIZE-1];
                     r_ovf     <= w_ovf;
                     r_q       <= w_mag_dd;
                     r_m       <= w_mag_dv;
                     r_a       <= '0;
                     r_cnt     <= '0;
                  end
               end
            end
            OPERA: begin
               r_a   <= w_neg ? w_shift_a : w_diff[SIZE:0];
               r_q   <= {r_q[SIZE-2:0], ~w_neg};
               r_cnt <= r_cnt + c_CNT_W'(1);
            end
            AJUSTE: begin
               // Overflow case wraps naturally: |min|/1 leaves Q = 2^(SIZE-1).
               r_cociente <= (r_sign_dd ^ r_sign_dv) ? -r_q : r_q;
               r_resto    <= r_sign_dd ? -r_a[SIZE-1:0] : r_a[SIZE-1:0];
               r_error    <= r_ovf;
            end
            default: begin
               r_error <= r_error;
            end
         endcase
      end
   end

   assign cociente = r_cociente;
   assign resto    = r_resto;
   assign Error    = r_error;
   assign Fin      = (r_state == FIN);

endmodule
`default_nettype wire

// File: tb/tb_divisor_secuencial.sv
`default_nettype none
// ============================================================================
// Module  : tb_divisor_secuencial
// Brief   : Directed and exhaustive checks of the sequential signed divider.
// Revision: 1.0 - initial release
// ============================================================================
module tb_divisor_secuencial;

   logic       clk;
   logic       reset;
   logic       Inicio;
   logic [3:0] dividendo;
   logic [3:0] divisor;
   logic [3:0] cociente;
   logic [3:0] resto;
   logic       Fin;
   logic       Error;

   int n_tests = 0;
   int n_fail  = 0;

   divisor_secuencial #(.SIZE(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .Inicio    (Inicio),
      .dividendo (dividendo),
      .divisor   (divisor),
      .cociente  (cociente),
      .resto     (resto),
      .Fin       (Fin),
      .Error     (Error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse Inicio for one edge (E0); lat counts edges after E0 until Fin is seen.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, output int lat);
      @(negedge clk);
      dividendo = a;
      divisor   = b;
      Inicio    = 1'b1;
      @(negedge clk);
      Inicio = 1'b0;
      lat    = 0;
      while (!Fin && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check_eq("fin_seen", {31'b0, Fin}, 32'd1);
   endtask

   task automatic do_dir(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                         input logic [3:0] er, input logic ee, input int elat);
      int lat;
      run_op(a, b, lat);
      check_eq("cociente", {28'b0, cociente}, {28'b0, eq});
      check_eq("resto",    {28'b0, resto},    {28'b0, er});
      check_eq("error",    {31'b0, Error},    {31'b0, ee});
      check_eq("latency",  lat,               elat);
   endtask

   task automatic ref_div(input logic [3:0] a, input logic [3:0] b,
                          output logic [3:0] q, output logic [3:0] r, output logic e);
      int sa;
      int sb;
      sa = $signed(a);
      sb = $signed(b);
      if (sb == 0) begin
         q = 4'hF;
         r = a;
         e = 1'b1;
      end else begin
         q = 4'(sa / sb);
         r = 4'(sa % sb);
         e = (sa == -8) && (sb == -1);
      end
   endtask

   initial begin
      int         lat;
      int         n;
      logic [3:0] mq;
      logic [3:0] mr;
      logic       me;

      reset     = 1'b1;
      Inicio    = 1'b0;
      dividendo = 4'd0;
      divisor   = 4'd0;
      repeat (2) @(negedge clk);
      check_eq("rst_fin",      {31'b0, Fin},      32'd0);
      check_eq("rst_error",    {31'b0, Error},    32'd0);
      check_eq("rst_cociente", {28'b0, cociente}, 32'd0);
      check_eq("rst_resto",    {28'b0, resto},    32'd0);
      reset = 1'b0;

      do_dir(4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 5);
      do_dir(4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 5);
      do_dir(4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0, 5);
      do_dir(4'b1001, 4'b1110, 4'b0011, 4'b1111, 1'b0, 5);
      do_dir(4'b0000, 4'b0011, 4'b0000, 4'b0000, 1'b0, 5);
      do_dir(4'b0101, 4'b0000, 4'b1111, 4'b0101, 1'b1, 0);
      do_dir(4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b1, 5);

      // 6/3 with Inicio and operands disturbed during OPERA
      @(negedge clk);
      dividendo = 4'd6;
      divisor   = 4'd3;
      Inicio    = 1'b1;
      @(negedge clk);
      check_eq("accept_fin",   {31'b0, Fin},      32'd0);
      check_eq("accept_error", {31'b0, Error},    32'd0);
      check_eq("hold_cociente", {28'b0, cociente}, 32'h8);
      for (int i = 0; i < 3; i++) begin
         Inicio    = (i % 2 == 0);
         dividendo = 4'($urandom);
         divisor   = 4'd0;
         @(negedge clk);
      end
      Inicio = 1'b0;
      lat    = 3;
      while (!Fin && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check_eq("ctl_latency",  lat,               32'd5);
      check_eq("ctl_cociente", {28'b0, cociente}, 32'h2);
      check_eq("ctl_resto",    {28'b0, resto},    32'h0);

      // Inicio held high: back-to-back operation out of FIN
      @(negedge clk);
      dividendo = 4'd7;
      divisor   = 4'd2;
      Inicio    = 1'b1;
      @(negedge clk);
      lat = 0;
      while (!Fin && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check_eq("b2b_lat1",      lat,               32'd5);
      check_eq("b2b_cociente1", {28'b0, cociente}, 32'h3);
      dividendo = 4'b1001;
      n = 0;
      do begin
         @(negedge clk);
         if (!Fin) n++;
      end while (!Fin && n < 20);
      Inicio = 1'b0;
      check_eq("b2b_fin_low",   n,                 32'd5);
      check_eq("b2b_cociente2", {28'b0, cociente}, 32'hD);
      check_eq("b2b_resto2",    {28'b0, resto},    32'hF);

      // Reset between E1 and E2 clears everything asynchronously
      @(negedge clk);
      dividendo = 4'd7;
      divisor   = 4'd2;
      Inicio    = 1'b1;
      @(negedge clk);
      Inicio = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_eq("mid_rst_fin",      {31'b0, Fin},      32'd0);
      check_eq("mid_rst_cociente", {28'b0, cociente}, 32'd0);
      check_eq("mid_rst_resto",    {28'b0, resto},    32'd0);
      check_eq("mid_rst_error",    {31'b0, Error},    32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_eq("idle_fin", {31'b0, Fin}, 32'd0);
      do_dir(4'd3, 4'd2, 4'b0001, 4'b0001, 1'b0, 5);

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            ref_div(4'(a), 4'(b), mq, mr, me);
            run_op(4'(a), 4'(b), lat);
            check_eq("all_cociente", {28'b0, cociente}, {28'b0, mq});
            check_eq("all_resto",    {28'b0, resto},    {28'b0, mr});
            check_eq("all_error",    {31'b0, Error},    {31'b0, me});
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
